// File: rtl/branch_seq_pkg.sv
// Shared constants and FSM state type for the control-transfer sequencer.
// Opcode, funct and REGIMM rt encodings for the MIPS branch and jump family.
package branch_seq_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    localparam logic [4:0] LINK_REG   = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/branch_sequencer_target.sv
// Combinational address generation: pc+4, branch target and jump target.
// All sums wrap modulo 2^32.
module pc_target_calc
    import branch_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] pc4,
    output logic [31:0] br_target,
    output logic [31:0] j_target
);

    logic [31:0] br_off;
    logic        unused_op;

    assign unused_op = ^instr[31:26];

    assign pc4       = pc + 32'd4;
    assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_target = pc4 + br_off;
    assign j_target  = {pc4[31:28], instr[25:0], 2'b00};

endmodule

// File: rtl/branch_sequencer.sv
// Three-state branch/jump sequencer: latch operands, evaluate, commit PC.
// Every output comes straight from a flop; inputs only reach the _d logic.
module branch_sequencer
    import branch_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             cmp_taken,
    output logic [31:0]      cmp_opa,
    output logic [31:0]      cmp_opb,
    output logic [5:0]       cmp_op,
    output logic [4:0]       cmp_funct,
    output logic [31:0]      pc_next,
    output logic             pc_we,
    output logic             link_we,
    output logic [4:0]       link_addr,
    output logic [31:0]      link_data,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_count
);

    state_e             state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        rs_q, rs_d;
    logic [31:0]        rt_q, rt_d;
    logic [31:0]        pc_next_q, pc_next_d;
    logic               pc_we_q, pc_we_d;
    logic               link_we_q, link_we_d;
    logic [4:0]         link_addr_q, link_addr_d;
    logic [31:0]        link_data_q, link_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;
    logic               taken_q, taken_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [31:0]        pc4, br_tgt, j_tgt, target;
    logic               is_cond, is_jmp, is_jr, is_link, legal, take;
    logic [4:0]         lnk_addr;

    pc_target_calc u_tgt (
        .pc        (pc_q),
        .instr     (instr_q),
        .pc4       (pc4),
        .br_target (br_tgt),
        .j_target  (j_tgt)
    );

    // Classify the latched instruction and pick its target.
    always_comb begin
        is_cond  = 1'b0;
        is_jmp   = 1'b0;
        is_jr    = 1'b0;
        is_link  = 1'b0;
        lnk_addr = LINK_REG;
        case (instr_q[31:26])
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_cond = 1'b1;
            OP_REGIMM: is_cond = (instr_q[20:16] == RT_BLTZ) ||
                                 (instr_q[20:16] == RT_BGEZ);
            OP_J:   is_jmp = 1'b1;
            OP_JAL: begin
                is_jmp  = 1'b1;
                is_link = 1'b1;
            end
            OP_SPECIAL: begin
                if (instr_q[5:0] == FN_JR) begin
                    is_jr = 1'b1;
                end else if (instr_q[5:0] == FN_JALR) begin
                    is_jr    = 1'b1;
                    is_link  = 1'b1;
                    lnk_addr = instr_q[15:11];
                end
            end
            default: ;
        endcase
        legal  = is_cond | is_jmp | is_jr;
        take   = is_cond ? cmp_taken : (is_jmp | is_jr);
        target = is_jr ? rs_q : (is_jmp ? j_tgt : br_tgt);
    end

    // Next-state and registered-output logic for IDLE/EVAL/COMMIT.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        pc_next_d   = pc_next_q;
        link_addr_d = link_addr_q;
        link_data_d = link_data_q;
        busy_d      = busy_q;
        taken_d     = taken_q;
        count_d     = count_q;
        pc_we_d     = 1'b0;
        link_we_d   = 1'b0;
        done_d      = 1'b0;
        illegal_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    instr_d = instr;
                    pc_d    = pc;
                    rs_d    = rs_val;
                    rt_d    = rt_val;
                    busy_d  = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                pc_we_d     = 1'b1;
                done_d      = 1'b1;
                illegal_d   = ~legal;
                link_we_d   = is_link;
                link_data_d = pc4;
                taken_d     = legal & take;
                pc_next_d   = (legal & take) ? target : pc4;
                if (is_link) begin
                    link_addr_d = lnk_addr;
                end
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                busy_d = 1'b0;
                if (taken_q && (count_q != '1)) begin
                    count_d = count_q + CNT_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any in-flight transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            pc_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            pc_next_q   <= '0;
            pc_we_q     <= 1'b0;
            link_we_q   <= 1'b0;
            link_addr_q <= '0;
            link_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            taken_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            pc_next_q   <= pc_next_d;
            pc_we_q     <= pc_we_d;
            link_we_q   <= link_we_d;
            link_addr_q <= link_addr_d;
            link_data_q <= link_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            taken_q     <= taken_d;
            count_q     <= count_d;
        end
    end

    assign cmp_opa     = rs_q;
    assign cmp_opb     = rt_q;
    assign cmp_op      = instr_q[31:26];
    assign cmp_funct   = instr_q[20:16];
    assign pc_next     = pc_next_q;
    assign pc_we       = pc_we_q;
    assign link_we     = link_we_q;
    assign link_addr   = link_addr_q;
    assign link_data   = link_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign taken_count = count_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed cases plus random instruction mix.
// Expected values come from an instruction-level reference model.
module tb_branch_sequencer;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      instr = '0;
    logic [31:0]      pc = '0;
    logic [31:0]      rs_val = '0;
    logic [31:0]      rt_val = '0;
    logic             cmp_taken;
    logic [31:0]      cmp_opa, cmp_opb, pc_next, link_data;
    logic [5:0]       cmp_op;
    logic [4:0]       cmp_funct, link_addr;
    logic             pc_we, link_we, busy, done, illegal;
    logic [CNT_W-1:0] taken_count;

    int nchk = 0;
    int nerr = 0;
    int cnt  = 0;

    branch_sequencer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instr       (instr),
        .pc          (pc),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .cmp_taken   (cmp_taken),
        .cmp_opa     (cmp_opa),
        .cmp_opb     (cmp_opb),
        .cmp_op      (cmp_op),
        .cmp_funct   (cmp_funct),
        .pc_next     (pc_next),
        .pc_we       (pc_we),
        .link_we     (link_we),
        .link_addr   (link_addr),
        .link_data   (link_data),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .taken_count (taken_count)
    );

    always #5 clk = ~clk;

    // Branch condition semantics of the MIPS comparator.
    function automatic logic cond_true(input logic [5:0] op,
                                       input logic [4:0] rt,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        case (op)
            6'd4: return a == b;
            6'd5: return a != b;
            6'd6: return $signed(a) <= 0;
            6'd7: return $signed(a) > 0;
            6'd1: begin
                if (rt == 5'd0) return $signed(a) < 0;
                if (rt == 5'd1) return $signed(a) >= 0;
                return 1'b0;
            end
            default: return 1'b0;
        endcase
    endfunction

    assign cmp_taken = cond_true(cmp_op, cmp_funct, cmp_opa, cmp_opb);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction-level reference: what the PC and link file should see.
    task automatic model(input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] npc, output logic lnk,
                         output logic [4:0] la, output logic ill,
                         output logic tk);
        logic [31:0] p4;
        logic [5:0]  op;
        logic [15:0] imm;
        p4  = p + 32'd4;
        op  = ins[31:26];
        imm = ins[15:0];
        npc = p4;
        lnk = 1'b0;
        la  = 5'd31;
        ill = 1'b0;
        tk  = 1'b0;
        if (op inside {6'd4, 6'd5, 6'd6, 6'd7} ||
            (op == 6'd1 && ins[20:16] <= 5'd1)) begin
            tk = cond_true(op, ins[20:16], a, b);
            if (tk) npc = 32'(p4 + 4 * int'($signed(imm)));
        end else if (op == 6'd2 || op == 6'd3) begin
            tk  = 1'b1;
            npc = (p4 & 32'hF000_0000) + 32'(ins[25:0]) * 4;
            lnk = (op == 6'd3);
        end else if (op == 6'd0 && (ins[5:0] == 6'd8 || ins[5:0] == 6'd9)) begin
            tk  = 1'b1;
            npc = a;
            lnk = (ins[5:0] == 6'd9);
            la  = ins[15:11];
        end else begin
            ill = 1'b1;
        end
    endtask

    task automatic run_op(input logic [31:0] ins, input logic [31:0] p,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] npc;
        logic        lnk, ill, tk;
        logic [4:0]  la;
        model(ins, p, a, b, npc, lnk, la, ill, tk);
        @(negedge clk);
        start = 1'b1; instr = ins; pc = p; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        instr = $urandom; rs_val = $urandom; rt_val = $urandom;
        chk("eval_busy", 32'(busy), 32'd1);
        chk("eval_done", 32'(done), 32'd0);
        chk("eval_opa", cmp_opa, a);
        chk("eval_opb", cmp_opb, b);
        chk("eval_op", 32'(cmp_op), 32'(ins[31:26]));
        chk("eval_funct", 32'(cmp_funct), 32'(ins[20:16]));
        @(negedge clk);
        chk("commit_done", 32'(done), 32'd1);
        chk("commit_pcwe", 32'(pc_we), 32'd1);
        chk("commit_busy", 32'(busy), 32'd1);
        chk("pc_next", pc_next, npc);
        chk("illegal", 32'(illegal), 32'(ill));
        chk("link_we", 32'(link_we), 32'(lnk));
        chk("commit_opa", cmp_opa, a);
        if (lnk) begin
            chk("link_addr", 32'(link_addr), 32'(la));
            chk("link_data", link_data, p + 32'd4);
        end
        if (tk && cnt < CMAX) cnt++;
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_pcwe", 32'(pc_we), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("taken_count", 32'(taken_count), 32'(cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[31:26] = 6'd4;
            1: r[31:26] = 6'd5;
            2: r[31:26] = 6'd6;
            3: r[31:26] = 6'd7;
            4: begin
                r[31:26] = 6'd1;
                r[20:16] = 5'($urandom_range(0, 3));
            end
            5: r[31:26] = 6'd2;
            6: r[31:26] = 6'd3;
            7: begin
                r[31:26] = 6'd0;
                r[5:0]   = 6'($urandom_range(7, 10));
            end
            8: r[31:26] = 6'h23;
            default: r[31:26] = 6'($urandom_range(8, 63));
        endcase
        return r;
    endfunction

    initial begin
        int ndone;
        logic [31:0] a, b;

        repeat (2) @(negedge clk);
        chk("rst_pcwe", 32'(pc_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pcnext", pc_next, 32'd0);
        chk("rst_count", 32'(taken_count), 32'd0);
        chk("rst_opa", cmp_opa, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(mk(6'd4, 5'd1, 5'd2, 16'h0003), 32'h3000, 32'd5, 32'd5);
        run_op(mk(6'd5, 5'd1, 5'd2, 16'hFFFF), 32'h3000, 32'd9, 32'd9);
        run_op(mk(6'd5, 5'd1, 5'd2, 16'hFFFF), 32'h3000, 32'd9, 32'd8);
        run_op({6'd3, 26'h0000C10}, 32'h3000, 32'd0, 32'd0);
        run_op({6'd0, 5'd4, 5'd0, 5'd7, 5'd0, 6'd9}, 32'h100,
               32'h0040_0020, 32'd1);
        run_op(mk(6'd4, 5'd1, 5'd2, 16'h0001), 32'hFFFF_FFFC, 32'd3, 32'd3);
        run_op(mk(6'h23, 5'd1, 5'd2, 16'h0010), 32'h0000_2000, 32'd1, 32'd2);
        run_op(mk(6'd1, 5'd1, 5'd2, 16'h0010), 32'h0000_2000, 32'd1, 32'd2);

        // A second start while EVAL is in progress must not be queued.
        @(negedge clk);
        start = 1'b1; instr = mk(6'd4, 5'd1, 5'd2, 16'h0004);
        pc = 32'h500; rs_val = 32'd1; rt_val = 32'd1;
        @(negedge clk);
        instr = {6'd2, 26'h123};
        ndone = 0;
        @(negedge clk);
        start = 1'b0;
        if (done) ndone++;
        chk("dbl_pcnext", pc_next, 32'h0000_0514);
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        if (cnt < CMAX) cnt++;
        chk("dbl_ndone", 32'(ndone), 32'd1);
        chk("dbl_count", 32'(taken_count), 32'(cnt));

        // Reset in EVAL aborts the transfer.
        @(negedge clk);
        start = 1'b1; instr = {6'd2, 26'h3F};
        pc = 32'h700; rs_val = 32'hDEAD; rt_val = 32'hBEEF;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pcwe", 32'(pc_we), 32'd0);
        chk("abort_pcnext", pc_next, 32'd0);
        chk("abort_opa", cmp_opa, 32'd0);
        chk("abort_linkdata", link_data, 32'd0);
        chk("abort_count", 32'(taken_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (pc_we || done) ndone++;
        end
        chk("abort_no_write", 32'(ndone), 32'd0);

        // Saturation: 2^CNT_W + 2 taken jumps.
        do_reset();
        for (int i = 0; i < CMAX + 3; i++) begin
            run_op({6'd2, 26'($urandom)}, $urandom, $urandom, $urandom);
        end
        chk("sat_count", 32'(taken_count), 32'(CMAX));

        // Random mix against the reference model.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0, 1: b = a;
                2: a = 32'd0;
                default: ;
            endcase
            run_op(rand_instr(), $urandom, a, b);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle control-transfer sequencer for the MIPS core. It is started by the main control FSM when the instruction register holds a branch or jump. It drives the combinational branch comparator with latched operands and computes the branch or jump target. It then issues a single-cycle PC write and, for JAL and JALR, a register-file link write. It sits between the main control unit, the register file read ports, the branch comparator and the PC register.

## Interface
Parameters:
- `CNT_W`, default 16: width of the taken-transfer counter.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle request from the main control FSM. Sampled only in IDLE.
- `instr`, in, 32: instruction word; sampled with `start`.
- `pc`, in, 32: address of that instruction; sampled with `start`.
- `rs_val`, in, 32: register-file rs operand; sampled with `start`.
- `rt_val`, in, 32: register-file rt operand; sampled with `start`.
- `cmp_taken`, in, 1: comparator result; sampled at the end of EVAL.
- `cmp_opa`, out, 32: comparator operand A, equal to latched rs.
- `cmp_opb`, out, 32: comparator operand B, equal to latched rt.
- `cmp_op`, out, 6: latched opcode, sent to the comparator.
- `cmp_funct`, out, 5: latched instr[20:16], sent to the comparator.
- `pc_next`, out, 32: new PC value; valid while `pc_we` is high.
- `pc_we`, out, 1: one-cycle PC write strobe.
- `link_we`, out, 1: one-cycle register-file write strobe for the link value.
- `link_addr`, out, 5: link destination register.
- `link_data`, out, 32: link value, pc+4.
- `busy`, out, 1: high in EVAL and COMMIT.
- `done`, out, 1: one-cycle completion pulse, coincident with `pc_we`.
- `illegal`, out, 1: qualifies `done`; the instruction was not a recognised control transfer.
- `taken_count`, out, CNT_W: saturating count of taken transfers.

## Operation
- FSM states are IDLE, EVAL and COMMIT; each transition takes one cycle.
- IDLE with `start`=1: latch instr, pc, rs_val and rt_val, then go to EVAL. With `start`=0, stay in IDLE.
- EVAL: `cmp_*` outputs carry the latched values. At the clock edge, register `cmp_taken`, the computed target and the classification, then go to COMMIT.
- COMMIT: assert `pc_we` and `done` for exactly one cycle. Assert `link_we` if the instruction is a link instruction. Return to IDLE.
- The `cmp_*` outputs are held stable from EVAL through COMMIT. In IDLE they hold their last values.
- Instruction classes:
  - BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111: conditional; taken = `cmp_taken`.
  - REGIMM 000001 with rt=00000 (BLTZ) or rt=00001 (BGEZ): conditional. Any other rt value is illegal.
  - J 000010: unconditional.
  - JAL 000011: unconditional, links to register 31.
  - SPECIAL 000000 with funct 001000 (JR): unconditional, target is rs.
  - SPECIAL 000000 with funct 001001 (JALR): unconditional, target is rs, links to rd.
  - Every other opcode or funct is illegal.
- Arithmetic (all 32-bit, wrapping modulo 2^32):
  - pc4 = pc + 4.
  - Branch target = pc4 + (sign_extend(instr[15:0]) << 2).
  - J/JAL target = {pc4[31:28], instr[25:0], 2'b00}.
- `pc_next` by case:
  - Taken: the target.
  - Not-taken conditional: pc4.
  - Illegal: pc4, with `illegal`=1.
- `link_data` = pc4. JR and JALR targets are used unmodified; the low bits are not checked.
- `taken_count` increments in COMMIT when the transfer is taken, which includes all legal jumps. It saturates at all-ones.
- `start` while busy is ignored; no queueing. The main control FSM must not pulse `start` again before `done`.

## Timing
- Latency: `start` sampled at edge N, EVAL occupies cycle N+1, COMMIT occupies cycle N+2. `done`, `pc_we` and `link_we` are high during N+2 only.
- Throughput: one instruction per 3 cycles. A `start` in the cycle where `done` is high is ignored. The earliest accepted `start` is in the cycle after `done`, with the FSM back in IDLE.
- `cmp_taken` must settle combinationally within the EVAL cycle.
- All outputs are registered. No combinational path runs from any input to `pc_we`, `done`, `link_we` or `pc_next`.
- Reset values: FSM IDLE, `pc_we`=0, `link_we`=0, `done`=0, `illegal`=0, `busy`=0, `pc_next`=0, `link_data`=0, `link_addr`=0, `cmp_opa`=0, `cmp_opb`=0, `cmp_op`=0, `cmp_funct`=0, `taken_count`=0.
- Reset asserted mid-operation (EVAL or COMMIT): the FSM immediately returns to IDLE and all strobes drop asynchronously. No PC or link write is issued for the aborted instruction.

## Structure
- Shared package `branch_seq_pkg` holds:
  - Opcode constants OP_SPECIAL, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ.
  - Funct constants FN_JR, FN_JALR.
  - REGIMM rt codes RT_BLTZ, RT_BGEZ.
  - The FSM state enum and the link register constant (31).
- One combinational sub-module, `pc_target_calc`: inputs pc and instr, outputs pc4, branch target and jump target. It is instantiated once.

## Test plan
- BEQ, pc=0x00003000, imm=0x0003, rs=rt=5 → `pc_next`=0x00003010. `done` and `pc_we` high exactly 2 cycles after `start`; `link_we`=0; `taken_count`=1.
- BNE, imm=0xFFFF, rs=rt → not taken, `pc_next`=0x00003004, count unchanged. With rs≠rt → `pc_next`=0x00003000.
- JAL, pc=0x00003000, index 0x0000C10 → `pc_next`=0x00003040, `link_we`=1, `link_addr`=31, `link_data`=0x00003004.
- JALR, rd=7, rs=0x00400020 → `pc_next`=0x00400020, `link_addr`=7. Wrap case: pc=0xFFFFFFFC, BEQ taken, imm=1 → `pc_next`=0x00000004.
- Opcode 0x23 (LW) → `done`=1, `illegal`=1, `pc_next`=pc+4, no link write. REGIMM with rt=00010 → `illegal`=1.
- Protocol and reset cases:
  - Second `start` during EVAL is ignored; only one `done` is produced.
  - `rst` pulsed during EVAL → no `pc_we` follows and all outputs read 0.
  - After 2^CNT_W+2 taken branches, `taken_count` holds all-ones.
